// File: rtl/mips_mem_pkg.sv
// Shared types and the address decode helper for the MIPS memory responder.
package mips_mem_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        LOAD  = 2'd2
    } mem_state_t;

    typedef struct packed {
        logic        ok;
        logic [31:0] idx;
    } decode_t;

    // Range test runs in 33 bits so a window ending at the top of the space does not wrap.
    function automatic decode_t in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input int unsigned depth);
        decode_t     d;
        logic [32:0] a;
        logic [32:0] lo;
        logic [32:0] hi;
        a     = {1'b0, addr};
        lo    = {1'b0, base};
        hi    = lo + (33'(depth) << 2);
        d.ok  = (a >= lo) && (a < hi);
        d.idx = (addr - base) >> 2;
        return d;
    endfunction

endpackage

// File: rtl/mips_mem_array.sv
// Word array with one write port and two synchronous read ports (read-before-write).
module mips_mem_array
    import mips_mem_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic              a_en,
    input  logic [AW-1:0]     a_addr,
    output logic [WORD_W-1:0] a_rdata,
    input  logic              b_en,
    input  logic [AW-1:0]     b_addr,
    output logic [WORD_W-1:0] b_rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        if (a_en)
            a_rdata <= mem[a_addr];
        if (b_en)
            b_rdata <= mem[b_addr];
    end

endmodule

// File: rtl/mips_memory.sv
// Unified fetch/data memory responder: zero-fills after reset, then optionally streams in an image.
module mips_memory
    import mips_mem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h8002_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       instr_addr,
    output logic [31:0]       instr_rdata,
    input  logic [31:0]       data_addr,
    input  logic              data_rd_wr,
    input  logic [31:0]       data_wdata,
    output logic [31:0]       data_rdata,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [31:0]       load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              mem_ready,
    output logic              addr_fault,
    output mem_state_t        dbg_state
);

    // Load handshake: a word transfers on any posedge where load_valid && load_ready.
    localparam int            AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH_WORDS - 1);

    mem_state_t        state;
    logic [AW-1:0]     ptr;
    logic              instr_ok_q;
    logic              data_ok_q;

    decode_t           i_dec;
    decode_t           d_dec;
    logic              i_ok;
    logic              d_ok;
    logic              i_mis;
    logic              d_mis;

    logic              we;
    logic [AW-1:0]     waddr;
    logic [WORD_W-1:0] wdata;
    logic              a_en;
    logic              b_en;
    logic [WORD_W-1:0] a_rdata;
    logic [WORD_W-1:0] b_rdata;

    assign i_dec = in_range(instr_addr, BASE_ADDR, DEPTH_WORDS);
    assign d_dec = in_range(data_addr, BASE_ADDR, DEPTH_WORDS);
    // Upper index bits are always zero when in range; folding them in keeps the check self-contained.
    assign i_ok  = i_dec.ok && ((i_dec.idx >> AW) == 32'd0);
    assign d_ok  = d_dec.ok && ((d_dec.idx >> AW) == 32'd0);
    assign i_mis = instr_addr[1:0] != 2'b00;
    assign d_mis = data_addr[1:0] != 2'b00;

    always_comb begin
        we    = 1'b0;
        waddr = ptr;
        wdata = '0;
        case (state)
            CLEAR: begin
                we = 1'b1;
            end
            LOAD: begin
                we    = load_valid && load_ready;
                wdata = load_data;
            end
            IDLE: begin
                we    = !data_rd_wr && d_ok;
                waddr = d_dec.idx[AW-1:0];
                wdata = data_wdata;
            end
            default: we = 1'b0;
        endcase
    end

    assign a_en = (state == IDLE);
    assign b_en = (state == IDLE) && data_rd_wr && d_ok;

    mips_mem_array #(
        .DEPTH (DEPTH_WORDS),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .a_en    (a_en),
        .a_addr  (i_dec.idx[AW-1:0]),
        .a_rdata (a_rdata),
        .b_en    (b_en),
        .b_addr  (d_dec.idx[AW-1:0]),
        .b_rdata (b_rdata)
    );

    // Out-of-range or inert reads are forced to zero, which the core decodes as a nop.
    assign instr_rdata = instr_ok_q ? a_rdata : '0;
    assign data_rdata  = data_ok_q  ? b_rdata : '0;
    assign dbg_state   = state;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= CLEAR;
            ptr        <= '0;
            load_ready <= 1'b0;
            mem_ready  <= 1'b0;
            addr_fault <= 1'b0;
            instr_ok_q <= 1'b0;
            data_ok_q  <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    instr_ok_q <= 1'b0;
                    data_ok_q  <= 1'b0;
                    ptr        <= ptr + 1'b1;
                    if (ptr == LAST_IDX) begin
                        state     <= IDLE;
                        mem_ready <= 1'b1;
                    end
                end
                IDLE: begin
                    instr_ok_q <= i_ok;
                    if (data_rd_wr)
                        data_ok_q <= d_ok;
                    if (!i_ok || i_mis || !d_ok || d_mis)
                        addr_fault <= 1'b1;
                    if (load_start) begin
                        state      <= LOAD;
                        ptr        <= '0;
                        mem_ready  <= 1'b0;
                        load_ready <= 1'b1;
                    end
                end
                LOAD: begin
                    instr_ok_q <= 1'b0;
                    data_ok_q  <= 1'b0;
                    if (load_valid && load_ready) begin
                        ptr <= ptr + 1'b1;
                        if (load_last || ptr == LAST_IDX) begin
                            state      <= IDLE;
                            load_ready <= 1'b0;
                            mem_ready  <= 1'b1;
                        end
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

endmodule

// File: doc/mips_memory.md
Name: mips_memory

Overview:
- Unified word-addressed memory responder on the far end of the MIPS core's instruction-fetch and data-memory ports.
- Serves registered reads on the fetch port and reads/writes on the data port.
- After reset it zero-fills its array, then optionally accepts a streamed program image through a valid/ready load port.
- The system holds the core in reset until mem_ready is 1.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words; must be a power of two, at least 2.
- BASE_ADDR, 32'h8002_0000: byte address of word 0; must be 4-byte aligned.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-low reset (0 = reset).
- instr_addr  input  32  fetch byte address (core's instr_addr).
- instr_rdata  output  32  fetch data (to core's instr_in).
- data_addr  input  32  data byte address (core's data_addr).
- data_rd_wr  input  1  1 = read, 0 = write (core's data_rd_wr).
- data_wdata  input  32  store data (core's data_out).
- data_rdata  output  32  load data (to core's data_in).
- load_start  input  1  request image load; sampled only in IDLE.
- load_valid  input  1  load_data is valid.
- load_data  input  32  image word.
- load_last  input  1  qualifies the final image word.
- load_ready  output  1  loader accepts a word this cycle.
- mem_ready  output  1  array is serving the core.
- addr_fault  output  1  sticky flag for any illegal access.

Behaviour:
- Reset (reset=0 at posedge):
  - state<=CLEAR, ptr<=0.
  - instr_rdata, data_rdata, load_ready, mem_ready, addr_fault all <=0.
  - A reset asserted mid-CLEAR or mid-LOAD aborts that operation; the next cycle restarts CLEAR from word 0.
- Address decode, per port:
  - In range iff BASE_ADDR <= addr < BASE_ADDR+4*DEPTH_WORDS, computed in 33-bit arithmetic so the top of the space does not wrap.
  - idx = (addr-BASE_ADDR)>>2; addr[1:0] is ignored for indexing.
- CLEAR:
  - Writes 0 to word ptr each cycle, ptr++.
  - After the cycle that clears word DEPTH_WORDS-1: state<=IDLE, mem_ready<=1.
  - mem_ready first reads 1 exactly DEPTH_WORDS cycles after the first posedge with reset=1.
- IDLE:
  - Fetch: instr_rdata<=mem[idx(instr_addr)] every cycle, 1-cycle latency.
  - Data read (data_rd_wr=1): data_rdata<=mem[idx(data_addr)], 1-cycle latency.
  - Data write (data_rd_wr=0): mem[idx]<=data_wdata at the posedge; data_rdata holds its previous value.
  - Same-cycle fetch read and data write to one word: instr_rdata returns the OLD word (read-before-write). The new word is visible from the next cycle.
  - Out-of-range read returns 0, which the core decodes as a nop. Out-of-range write is dropped. Either sets addr_fault<=1.
  - Data access with addr[1:0]!=0 completes on the truncated index and sets addr_fault.
  - Fetch with instr_addr[1:0]!=0 completes the same way and also sets addr_fault.
  - load_start=1: state<=LOAD, ptr<=0, mem_ready<=0, load_ready<=1. Data or fetch activity in that same cycle is still served.
- LOAD:
  - Core ports are inert: reads return 0 and writes are dropped (no fault).
  - Transfer on load_valid&load_ready: mem[ptr]<=load_data, ptr++.
  - Transfer with load_last=1, or a transfer to word DEPTH_WORDS-1: state<=IDLE, load_ready<=0, mem_ready<=1 next cycle.
  - load_valid=0 simply stalls; there is no timeout.
  - Words beyond the last loaded word keep their prior contents.
- load_ready is 0 outside LOAD. load_start outside IDLE is ignored.
- addr_fault clears only on reset.

Decomposition:
- Package mips_mem_pkg:
  - mem_state_t enum {CLEAR, IDLE, LOAD}.
  - WORD_W=32.
  - Function in_range(addr, base, depth), returning a range flag and an index.
- Sub-module mips_mem_array:
  - One write port and two synchronous read ports, read-before-write.
  - The FSM muxes the write port between the clear, load and data-store sources.

Test Plan:
- Reset release with DEPTH_WORDS=16:
  - mem_ready rises exactly 16 cycles later.
  - Reads of BASE_ADDR+0x0 and +0x3C return 0.
  - addr_fault stays 0.
- Load 3 words:
  - Drive 0x24080005, 0x24090007, 0x01095021 (load_last on the third) with load_valid gaps inserted.
  - Fetch at BASE, +4, +8 returns them 1 cycle after the address.
  - Word 3 is still 0.
- Data write then read:
  - Write 0xDEADBEEF to BASE+0x10.
  - Read it on the next cycle; data_rdata=0xDEADBEEF one cycle later.
  - Same-cycle fetch of BASE+0x10 returns the old value 0.
- Faults:
  - Read at BASE-4 returns 0 and sets addr_fault.
  - Write at BASE+4*DEPTH is dropped.
  - Write at BASE+0x6 writes word 1 and leaves addr_fault=1.
  - addr_fault stays 1 until reset.
- Full-depth load without load_last:
  - 16 transfers fill all words; load_ready drops after the 16th.
  - mem_ready returns to 1.
  - A 17th load_valid is not accepted.
- Reset mid-LOAD after 2 words:
  - Reset pulsed 0 for one cycle.
  - load_ready=0 and mem_ready=0 immediately.
  - CLEAR re-runs; words 0 and 1 read 0 afterwards.
